mux_4_scan: RTL and testbench
=============================

MUX_4_SCAN -- requirements
Module: mux_4_scan

Interface
REQ-001 Parameter DWELL, default 4, SHALL set the clock cycles each channel is selected before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start  input  1  scan request; sampled on rising clk.
REQ-005 mask  input  4  channel enables, bit i = channel i (x1..x4 = bits 0..3).
REQ-006 y  input  1  data returned from the downstream 4:1 mux.
REQ-007 c  output  2  select code driven to the 4:1 mux.
REQ-008 sample  output  4  captured y per channel, bit i = channel i.
REQ-009 busy  output  1  high while scanning.
REQ-010 done  output  1  one-cycle pulse when the scan result is complete.
REQ-011 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-013 IDLE, start=1, mask!=0: SHALL latch mask, clear sample to 0, load c with lowest set mask bit, load dwell counter with DWELL-1, go to SCAN.
REQ-014 IDLE, start=1, mask=0: SHALL pulse err for one cycle, stay IDLE, leave sample unchanged.
REQ-015 SCAN: counter nonzero SHALL decrement with c held.
REQ-016 SCAN, counter=0: SHALL write y into sample[c]; if a higher latched-mask bit exists, c SHALL move to the next higher set bit and counter reload DWELL-1; else go to DONE.
REQ-017 Disabled channels SHALL never be selected and their sample bits SHALL read 0.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 exactly in SCAN; done and err SHALL never be high together.
REQ-020 Scan with N enabled channels SHALL occupy N*DWELL SCAN cycles; done SHALL assert in the cycle after the last capture.
REQ-021 start during SCAN or DONE SHALL be ignored (no err, no restart); mask changes during a scan SHALL have no effect.
REQ-022 c SHALL hold its last value in IDLE and DONE; sample SHALL hold until the next accepted start.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, c=2'b00, sample=4'b0000, busy=0, done=0, err=0, counter=0, latched mask=0.
REQ-024 Reset asserted mid-scan SHALL abort the scan with no done pulse; first start after release SHALL begin a fresh scan.

Structure
REQ-025 State encoding (IDLE/SCAN/DONE) and the channel count constant (4) SHALL live in a shared package.
REQ-026 Next-enabled-channel search SHALL be one sub-module, mux_4_next_sel (inputs current c, mask; outputs next c, valid).
REQ-027 Select output c SHALL come directly from a register (no combinational path from inputs to c).

Verification
REQ-028 DWELL=4, mask=4'b1111, y driven as channel pattern 1,0,1,1 -> busy 16 cycles, c steps 00,01,10,11 every 4 cycles, done pulse, sample=4'b1101.
REQ-029 mask=4'b1010, y=1 on all channels -> c visits 01 then 11 only, 8 busy cycles, sample=4'b1010.
REQ-030 start with mask=4'b0000 -> err one cycle, busy stays 0, sample unchanged.
REQ-031 start pulsed again and mask toggled mid-scan -> scan unaffected, single done pulse, no err.
REQ-032 rst_n low at cycle 6 of a 16-cycle scan -> outputs at reset values immediately, no done; new start with mask=4'b0001 completes in 4 cycles.
REQ-033 DWELL=1, mask=4'b1000 -> c=11 for 1 cycle, done the next cycle, sample[3]=y.

Source files
------------

// File: rtl/mux_4_scan_pkg.sv
// Shared types and constants for the 4-channel mux scanner.
package mux_4_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Lowest enabled channel of a mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] res;
        res = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (m[i]) res = SEL_W'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_4_next_sel.sv
// Finds the next enabled channel strictly above the current select code.
module mux_4_next_sel
    import mux_4_scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_c,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  nxt_c,
    output logic              valid
);

    // Walk downward so the last hit is the lowest channel above cur_c.
    always_comb begin
        nxt_c = cur_c;
        valid = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur_c))) begin
                nxt_c = SEL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4_scan.sv
// Sequencer that steps a 4:1 mux through enabled channels, dwelling on each before capturing y.
module mux_4_scan
    import mux_4_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] mask,
    input  logic              y,
    output logic [SEL_W-1:0]  c,
    output logic [NUM_CH-1:0] sample,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [SEL_W-1:0]   c_q, c_d;
    logic [NUM_CH-1:0]  sample_q, sample_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   nxt_c;
    logic               nxt_valid;

    mux_4_next_sel u_next_sel (
        .cur_c (c_q),
        .mask  (mask_q),
        .nxt_c (nxt_c),
        .valid (nxt_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        c_d      = c_q;
        sample_d = sample_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (|mask) begin
                        mask_d   = mask;
                        sample_d = '0;
                        c_d      = lowest_set(mask);
                        cnt_d    = RELOAD;
                        state_d  = ST_SCAN;
                        busy_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    sample_d[c_q] = y;
                    if (nxt_valid) begin
                        c_d   = nxt_c;
                        cnt_d = RELOAD;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            c_q      <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            c_q      <= c_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign c      = c_q;
    assign sample = sample_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mux_4_scan.sv
// Directed and randomized checks of the mux scanner against a channel-list reference model.
module tb_mux_4_scan;

    localparam int unsigned DW_A = 4;

    logic       clk;
    logic       rst_n;

    logic       start_a, y_a, busy_a, done_a, err_a;
    logic [3:0] mask_a, sample_a, y_pat_a;
    logic [1:0] c_a;

    logic       start_b, y_b, busy_b, done_b, err_b;
    logic [3:0] mask_b, sample_b, y_pat_b;
    logic [1:0] c_b;

    int n_assert;
    int n_fail;

    logic [3:0] exp_sample;
    logic [1:0] exp_c;

    mux_4_scan #(.DWELL(DW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mask(mask_a), .y(y_a),
        .c(c_a), .sample(sample_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    mux_4_scan #(.DWELL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mask(mask_b), .y(y_b),
        .c(c_b), .sample(sample_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Downstream 4:1 mux: y follows the per-channel pattern selected by c.
    assign y_a = y_pat_a[c_a];
    assign y_b = y_pat_b[c_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, ".busy"}, 8'(busy_a), 8'd0);
        check({tag, ".done"}, 8'(done_a), 8'd0);
        check({tag, ".err"}, 8'(err_a), 8'd0);
        check({tag, ".sample"}, 8'(sample_a), 8'(exp_sample));
        check({tag, ".c"}, 8'(c_a), 8'(exp_c));
    endtask

    // One request on instance A; the model is the ordered list of enabled channels.
    task automatic do_scan(input logic [3:0] m, input logic [3:0] pat, input bit disturb);
        int ch_q[$];
        y_pat_a = pat;
        mask_a  = m;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        if (m == 4'b0000) begin
            check("rej.err", 8'(err_a), 8'd1);
            check("rej.busy", 8'(busy_a), 8'd0);
            check("rej.done", 8'(done_a), 8'd0);
            check("rej.sample", 8'(sample_a), 8'(exp_sample));
            check("rej.c", 8'(c_a), 8'(exp_c));
            tick();
            check_idle_a("rej_after");
            return;
        end
        for (int ch = 0; ch < 4; ch++) if (m[ch]) ch_q.push_back(ch);
        foreach (ch_q[k]) begin
            for (int d = 0; d < int'(DW_A); d++) begin
                check("scan.busy", 8'(busy_a), 8'd1);
                check("scan.c", 8'(c_a), 8'(ch_q[k]));
                check("scan.done", 8'(done_a), 8'd0);
                check("scan.err", 8'(err_a), 8'd0);
                if (disturb) begin
                    start_a = 1'($urandom);
                    mask_a  = 4'($urandom);
                end
                tick();
            end
        end
        start_a    = 1'b0;
        exp_sample = pat & m;
        exp_c      = 2'(ch_q[$]);
        check("done.done", 8'(done_a), 8'd1);
        check("done.busy", 8'(busy_a), 8'd0);
        check("done.err", 8'(err_a), 8'd0);
        check("done.sample", 8'(sample_a), 8'(exp_sample));
        check("done.c", 8'(c_a), 8'(exp_c));
        tick();
        check_idle_a("post_done");
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        exp_sample = 4'b0000;
        exp_c      = 2'b00;
        start_a = 1'b0; mask_a = 4'b0000; y_pat_a = 4'b0000;
        start_b = 1'b0; mask_b = 4'b0000; y_pat_b = 4'b0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_idle_a("reset");
        check("reset.b_c", 8'(c_b), 8'd0);
        check("reset.b_sample", 8'(sample_b), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_idle_a("after_release");

        // All channels, y pattern 1,0,1,1 for channels 0..3.
        do_scan(4'b1111, 4'b1101, 1'b0);
        // Sparse mask: only channels 1 and 3 visited.
        do_scan(4'b1010, 4'b1111, 1'b0);
        // Empty mask is rejected and leaves the last result intact.
        do_scan(4'b0000, 4'b1111, 1'b0);
        // Start and mask jitter during the scan must not disturb it.
        do_scan(4'b0110, 4'b0100, 1'b1);

        for (int r = 0; r < 8; r++) begin
            do_scan(4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Mid-scan reset aborts without a done pulse.
        y_pat_a = 4'b1111;
        mask_a  = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        check("midreset.busy_before", 8'(busy_a), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_sample = 4'b0000;
        exp_c      = 2'b00;
        check_idle_a("midreset");
        repeat (2) begin
            tick();
            check("midreset.no_done", 8'(done_a), 8'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_idle_a("midreset_release");
        do_scan(4'b0001, 4'($urandom), 1'b0);

        // DWELL=1: single channel 3, one SCAN cycle then done.
        y_pat_b = 4'b1000;
        mask_b  = 4'b1000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b.scan_c", 8'(c_b), 8'd3);
        check("b.scan_busy", 8'(busy_b), 8'd1);
        check("b.scan_done", 8'(done_b), 8'd0);
        tick();
        check("b.done", 8'(done_b), 8'd1);
        check("b.busy", 8'(busy_b), 8'd0);
        check("b.sample", 8'(sample_b), 8'h8);
        check("b.c_hold", 8'(c_b), 8'd3);
        tick();
        check("b.done_clear", 8'(done_b), 8'd0);
        check("b.err", 8'(err_b), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
